// File: rtl/dram_arb_pkg.sv
// Shared types for the I/D DRAM port arbiter.
package dram_arb_pkg;

    localparam int DEF_BURST_LEN = 4;
    localparam int BEAT_W = $clog2(DEF_BURST_LEN);

    typedef enum logic {
        IDLE,
        WBURST
    } arb_state_t;

    typedef enum logic {
        SIDE_I,
        SIDE_D
    } side_t;

    function automatic side_t other_side(side_t s);
        return (s == SIDE_I) ? SIDE_D : SIDE_I;
    endfunction

endpackage

// File: rtl/dram_rd_tracker.sv
// One outstanding read per side: address, relative age and return beat count.
module dram_rd_tracker
    import dram_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int BURST_LEN = DEF_BURST_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              accept,
    input  logic [ADDR_W-1:0] addr,
    input  logic              other_pend,
    input  logic              other_done,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              beat,
    output logic              pending,
    output logic              age,
    output logic              match,
    output logic              done
);

    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST_LEN - 1);

    logic [ADDR_W-1:0] pend_addr;
    logic [CNT_W-1:0]  rbeat;

    assign match = pending & (raddr == pend_addr);
    assign done  = beat & (rbeat == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= 1'b0;
            pend_addr <= '0;
            age       <= 1'b0;
            rbeat     <= '0;
        end else begin
            if (accept) begin
                pending   <= 1'b1;
                pend_addr <= addr;
                // younger only if the other read is still outstanding after this cycle
                age       <= other_pend & ~other_done;
            end else if (other_done) begin
                age <= 1'b0;
            end
            if (done) begin
                pending <= 1'b0;
                rbeat   <= '0;
            end else if (beat) begin
                rbeat <= rbeat + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing the burst DRAM port between I and D adapters.
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [63:0]       i_wdata,
    output logic              i_ready,
    output logic [ADDR_W-1:0] i_raddr,
    output logic [63:0]       i_rdata,
    output logic              i_rvalid,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [63:0]       d_wdata,
    output logic              d_ready,
    output logic [ADDR_W-1:0] d_raddr,
    output logic [63:0]       d_rdata,
    output logic              d_rvalid,
    output logic [ADDR_W-1:0] dram_addr,
    output logic              dram_read,
    output logic              dram_write,
    output logic [63:0]       dram_wdata,
    input  logic              dram_ready,
    input  logic [ADDR_W-1:0] dram_raddr,
    input  logic [63:0]       dram_rdata,
    input  logic              dram_rvalid
);

    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST_LEN - 1);

    arb_state_t       state;
    side_t            owner;
    side_t            rr_last;
    logic [CNT_W-1:0] wbeat;

    side_t             gnt;
    logic              gnt_any;
    logic              i_elig, d_elig;
    logic              g_read, g_write;
    logic [ADDR_W-1:0] g_addr;
    logic [63:0]       g_wdata;
    logic              r_acc, w_acc;
    logic              i_acc, d_acc;

    logic i_pend, i_age, i_match, i_done, i_route;
    logic d_pend, d_age, d_match, d_done, d_route;

    always_comb begin
        i_elig  = i_write | (i_read & ~i_pend);
        d_elig  = d_write | (d_read & ~d_pend);
        gnt_any = 1'b0;
        gnt     = SIDE_I;
        if (rst) begin
            gnt_any = 1'b0;
        end else if (state == WBURST) begin
            gnt_any = 1'b1;
            gnt     = owner;
        end else if (i_elig && d_elig) begin
            gnt_any = 1'b1;
            gnt     = other_side(rr_last);
        end else if (i_elig) begin
            gnt_any = 1'b1;
            gnt     = SIDE_I;
        end else if (d_elig) begin
            gnt_any = 1'b1;
            gnt     = SIDE_D;
        end
    end

    always_comb begin
        g_addr  = (gnt == SIDE_D) ? d_addr : i_addr;
        g_wdata = (gnt == SIDE_D) ? d_wdata : i_wdata;
        g_write = gnt_any & ((gnt == SIDE_D) ? d_write : i_write);
        // reads only start from IDLE; a write on the same side takes precedence
        g_read  = gnt_any & (state == IDLE) & ~g_write
                & ((gnt == SIDE_D) ? d_read : i_read);
    end

    assign r_acc = g_read & dram_ready;
    assign w_acc = g_write & dram_ready;
    assign i_acc = r_acc & (gnt == SIDE_I);
    assign d_acc = r_acc & (gnt == SIDE_D);

    assign dram_addr  = gnt_any ? g_addr : '0;
    assign dram_wdata = gnt_any ? g_wdata : '0;
    assign dram_read  = g_read;
    assign dram_write = g_write;
    assign i_ready    = (g_read | g_write) & (gnt == SIDE_I) & dram_ready;
    assign d_ready    = (g_read | g_write) & (gnt == SIDE_D) & dram_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            owner   <= SIDE_I;
            rr_last <= SIDE_I;
            wbeat   <= '0;
        end else begin
            if (r_acc) rr_last <= gnt;
            unique case (state)
                IDLE: begin
                    if (w_acc) begin
                        state   <= WBURST;
                        owner   <= gnt;
                        rr_last <= gnt;
                        wbeat   <= CNT_W'(1);
                    end
                end
                WBURST: begin
                    if (w_acc) begin
                        if (wbeat == LAST) begin
                            state <= IDLE;
                            wbeat <= '0;
                        end else begin
                            wbeat <= wbeat + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    dram_rd_tracker #(
        .ADDR_W    (ADDR_W),
        .BURST_LEN (BURST_LEN)
    ) u_trk_i (
        .clk        (clk),
        .rst        (rst),
        .accept     (i_acc),
        .addr       (i_addr),
        .other_pend (d_pend),
        .other_done (d_done),
        .raddr      (dram_raddr),
        .beat       (i_route),
        .pending    (i_pend),
        .age        (i_age),
        .match      (i_match),
        .done       (i_done)
    );

    dram_rd_tracker #(
        .ADDR_W    (ADDR_W),
        .BURST_LEN (BURST_LEN)
    ) u_trk_d (
        .clk        (clk),
        .rst        (rst),
        .accept     (d_acc),
        .addr       (d_addr),
        .other_pend (i_pend),
        .other_done (i_done),
        .raddr      (dram_raddr),
        .beat       (d_route),
        .pending    (d_pend),
        .age        (d_age),
        .match      (d_match),
        .done       (d_done)
    );

    // same-line reads: the older request (age 0) drains first
    assign i_route = ~rst & dram_rvalid & i_match & (~d_match | ~i_age);
    assign d_route = ~rst & dram_rvalid & d_match & (~i_match | ~d_age);

    assign i_rvalid = i_route;
    assign i_raddr  = i_route ? dram_raddr : '0;
    assign i_rdata  = i_route ? dram_rdata : '0;
    assign d_rvalid = d_route;
    assign d_raddr  = d_route ? dram_raddr : '0;
    assign d_rdata  = d_route ? dram_rdata : '0;

`ifndef SYNTHESIS
    unexpected_rvalid: assert property (
        @(posedge clk) disable iff (rst)
        dram_rvalid |-> (i_match || d_match)
    );
`endif

endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Shares the single burst DRAM port between the instruction-side and data-side cacheline adapters.
- Arbitrates requests round-robin and locks the port for the full duration of a write burst.
- Tracks one outstanding read per side and steers returning read beats to the side that issued them.
- Sits between the two cacheline adapters and the top-level DRAM interface.

Parameters:
- BURST_LEN, 4, number of 64-bit beats per 256-bit cacheline. Write bursts and read returns are both this length.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_addr  in  ADDR_W  I-side request address
- i_read  in  1  I-side read request
- i_write  in  1  I-side write beat; tied 0 in current use but fully supported
- i_wdata  in  64  I-side write data
- i_ready  out  1  I-side request/beat accepted this cycle
- i_raddr  out  ADDR_W  I-side returned read address
- i_rdata  out  64  I-side returned read data
- i_rvalid  out  1  I-side returned beat valid
- d_addr, d_read, d_write, d_wdata, d_ready, d_raddr, d_rdata, d_rvalid: same set for the D-side
- dram_addr  out  ADDR_W  downstream address
- dram_read  out  1  downstream read
- dram_write  out  1  downstream write beat
- dram_wdata  out  64  downstream write data
- dram_ready  in  1  downstream accepts this cycle
- dram_raddr  in  ADDR_W  downstream return address
- dram_rdata  in  64  downstream return data
- dram_rvalid  in  1  downstream return beat valid

Behaviour:
- Reset state:
  - all outputs 0
  - state IDLE; rr_last = I
  - both pending flags 0; beat counters 0
- Request eligibility:
  - A side requests when read|write is high.
  - A read is eligible only if that side has no pending read; otherwise its ready stays 0.
- Grant (combinational, same cycle):
  - IDLE, one eligible side: grant that side.
  - IDLE, both eligible: grant the side that is not rr_last.
  - WBURST: grant is fixed to the lock owner; the other side's ready is 0.
- Muxing:
  - dram_addr/read/write/wdata = granted side's signals.
  - With no grant, dram_read = dram_write = 0.
  - granted_ready = dram_ready; the non-granted side's ready = 0.
- Read handshake (read & ready accepted):
  - Set pending[side] = 1, pend_addr[side] = addr, pend_age[side] = 1 if the other side is already pending, else 0.
  - Update rr_last = side.
  - Single cycle; no lock.
- Write handshake:
  - On the first accepted beat: state goes IDLE→WBURST, owner = side, wbeat = 1, rr_last = side.
  - Each subsequent accepted beat increments wbeat.
  - When beat BURST_LEN-1 is accepted, state returns to IDLE the next cycle.
  - If the owner drops write mid-burst, stay locked and wait.
- Returns (on dram_rvalid):
  - Compare dram_raddr with pend_addr of each pending side.
  - One match: route raddr/rdata with rvalid=1 to that side only.
  - Both match (same line): route to the side with pend_age=0 (older), until its burst completes.
  - No match: drop the beat; raise the sim-only assertion `unexpected_rvalid`.
  - Each routed beat increments rbeat[side]. On beat BURST_LEN-1: clear pending[side], clear rbeat, and clear the other side's pend_age.
- Simultaneous events:
  - A new read acceptance may coincide with a return to the other side.
  - A side's own final return beat and its next read request: ready stays 0 that cycle; acceptance happens in the earliest cycle after pending clears.
- Reset mid-burst or mid-return: abort immediately; all state returns to reset values.
- Latency: zero-cycle pass-through for request and return paths; no added registers on data.

Decomposition:
- Package dram_arb_pkg:
  - enum arb_state_t {IDLE, WBURST}
  - enum side_t {SIDE_I, SIDE_D}
  - localparam BEAT_W = $clog2(BURST_LEN)
- Sub-module dram_rd_tracker, instantiated once per side: holds pending, pend_addr, pend_age, rbeat; produces a match output and a done pulse.

Test Plan:
- Single I read 0x1eceb000, ready=1, then 4 rvalid beats with raddr 0x1eceb000 → i_rvalid high for 4 cycles, d_rvalid 0, i_pending clears after beat 4.
- I and D read in the same cycle, rr_last=I → D granted first (d_ready=1, i_ready=0); I granted the next cycle.
- D write burst to 0x1000 with ready toggling 1,0,1,1,1, while I requests a read throughout → i_ready stays 0 until the 4th D beat is accepted; I read is accepted the cycle after.
- Out-of-order returns: I pends 0x2000, D pends 0x3000; beats for 0x3000 arrive first → all routed to D, then I's beats to I.
- Both pend 0x4000 (I first) → first 4 beats go to I, next 4 to D.
- rst asserted during write beat 2 → the next cycle all outputs are 0, state is IDLE, and a fresh I read is accepted immediately.
